// File: rtl/pkt_con_rx_arb_if.sv
// Point-to-point inbound link bundle: 7 same-x links and 7 same-y links.
// mst drives flits toward the node; slv consumes them and returns rdy.
interface pkt_con_if #(
    parameter int TYPE_W = 2,
    parameter int ID_W   = 8,
    parameter int FLIT_W = 32
);
    logic [6:0]             x_vld, x_qos, x_rdy;
    logic [6:0][TYPE_W-1:0] x_type;
    logic [6:0][ID_W-1:0]   x_src, x_tgt;
    logic [6:0][FLIT_W-1:0] x_data;

    logic [6:0]             y_vld, y_qos, y_rdy;
    logic [6:0][TYPE_W-1:0] y_type;
    logic [6:0][ID_W-1:0]   y_src, y_tgt;
    logic [6:0][FLIT_W-1:0] y_data;

    modport mst (
        output x_vld, x_qos, x_type, x_src, x_tgt, x_data,
        output y_vld, y_qos, y_type, y_src, y_tgt, y_data,
        input  x_rdy, y_rdy
    );

    modport slv (
        input  x_vld, x_qos, x_type, x_src, x_tgt, x_data,
        input  y_vld, y_qos, y_type, y_src, y_tgt, y_data,
        output x_rdy, y_rdy
    );
endinterface

// File: rtl/pkt_con_rx_arb.sv
// Ejection arbiter: merges 14 inbound links into one stream using two-class
// QoS round-robin with low-class anti-starvation, buffered by a small FIFO.
module pkt_con_rx_arb #(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_LIM = 8,
    parameter int TYPE_W     = 2,
    parameter int ID_W       = 8,
    parameter int FLIT_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    pkt_con_if.slv            con,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic              out_qos,
    output logic [TYPE_W-1:0] out_type,
    output logic [ID_W-1:0]   out_src,
    output logic [ID_W-1:0]   out_tgt,
    output logic [FLIT_W-1:0] out_data,
    output logic [3:0]        out_port
);
    localparam int NL = 14;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic              qos;
        logic [TYPE_W-1:0] typ;
        logic [ID_W-1:0]   src;
        logic [ID_W-1:0]   tgt;
        logic [FLIT_W-1:0] data;
        logic [3:0]        port;
    } ent_t;

    logic [NL-1:0]             req, qos, hi, lo, cls_req, rdy;
    logic [NL-1:0][TYPE_W-1:0] typ_all;
    logic [NL-1:0][ID_W-1:0]   src_all, tgt_all;
    logic [NL-1:0][FLIT_W-1:0] data_all;

    logic [3:0]    ptr_hi_q, ptr_hi_d, ptr_lo_q, ptr_lo_d;
    logic [3:0]    ptr_sel, gnt_idx, gnt_nxt;
    logic [4:0]    idx;
    logic [7:0]    starve_q, starve_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    ent_t          mem_q [FIFO_DEPTH];
    ent_t          wr_ent, head;
    logic          space, sel_lo, found, push, pop;

    assign req      = {con.y_vld,  con.x_vld};
    assign qos      = {con.y_qos,  con.x_qos};
    assign typ_all  = {con.y_type, con.x_type};
    assign src_all  = {con.y_src,  con.x_src};
    assign tgt_all  = {con.y_tgt,  con.x_tgt};
    assign data_all = {con.y_data, con.x_data};

    assign hi = req & qos;
    assign lo = req & ~qos;

    // No pop-through: a full FIFO refuses a push even while it is draining.
    assign space   = cnt_q < CW'(FIFO_DEPTH);
    assign sel_lo  = ((starve_q == 8'(STARVE_LIM)) && (|lo)) || ~(|hi);
    assign cls_req = sel_lo ? lo : hi;
    assign ptr_sel = sel_lo ? ptr_lo_q : ptr_hi_q;

    always_comb begin
        found   = 1'b0;
        gnt_idx = ptr_sel;
        idx     = '0;
        for (int k = 0; k < NL; k++) begin
            idx = {1'b0, ptr_sel} + 5'(k);
            if (idx >= 5'(NL)) idx = idx - 5'(NL);
            if (!found && cls_req[idx[3:0]]) begin
                found   = 1'b1;
                gnt_idx = idx[3:0];
            end
        end
    end

    // rdy is masked by rst_n so every link is refused while reset is held.
    assign push    = rst_n && space && found;
    assign pop     = out_vld && out_rdy;
    assign rdy     = push ? (NL'(1) << gnt_idx) : '0;
    assign gnt_nxt = (gnt_idx == 4'(NL - 1)) ? 4'd0 : gnt_idx + 4'd1;

    assign con.x_rdy = rdy[6:0];
    assign con.y_rdy = rdy[13:7];

    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        ptr_hi_d = ptr_hi_q;
        ptr_lo_d = ptr_lo_q;
        if (push) begin
            if (sel_lo) ptr_lo_d = gnt_nxt;
            else        ptr_hi_d = gnt_nxt;
        end

        starve_d = starve_q;
        if (~(|lo))
            starve_d = '0;
        else if (push && sel_lo)
            starve_d = '0;
        else if (push && (starve_q != 8'(STARVE_LIM)))
            starve_d = starve_q + 8'd1;

        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        wr_d = push ? inc_ptr(wr_q) : wr_q;
        rd_d = pop  ? inc_ptr(rd_q) : rd_q;
    end

    always_comb begin
        wr_ent      = '0;
        wr_ent.qos  = qos[gnt_idx];
        wr_ent.typ  = typ_all[gnt_idx];
        wr_ent.src  = src_all[gnt_idx];
        wr_ent.tgt  = tgt_all[gnt_idx];
        wr_ent.data = data_all[gnt_idx];
        wr_ent.port = gnt_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_hi_q <= '0;
            ptr_lo_q <= '0;
            starve_q <= '0;
            cnt_q    <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            ptr_hi_q <= ptr_hi_d;
            ptr_lo_q <= ptr_lo_d;
            starve_q <= starve_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            if (push) mem_q[wr_q] <= wr_ent;
        end
    end

    assign head     = mem_q[rd_q];
    assign out_vld  = (cnt_q != '0);
    assign out_qos  = head.qos;
    assign out_type = head.typ;
    assign out_src  = head.src;
    assign out_tgt  = head.tgt;
    assign out_data = head.data;
    assign out_port = head.port;
endmodule

// File: tb/tb_pkt_con_rx_arb.sv
// Bench for pkt_con_rx_arb: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed grant sequences.
module tb_pkt_con_rx_arb;
    localparam int FIFO_DEPTH = 2;
    localparam int STARVE_LIM = 8;
    localparam int TYPE_W     = 2;
    localparam int ID_W       = 8;
    localparam int FLIT_W     = 32;
    localparam int NL         = 14;

    typedef struct packed {
        logic              qos;
        logic [TYPE_W-1:0] typ;
        logic [ID_W-1:0]   src;
        logic [ID_W-1:0]   tgt;
        logic [FLIT_W-1:0] data;
        logic [3:0]        port;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic out_rdy = 1'b0;
    logic out_vld, out_qos;
    logic [TYPE_W-1:0] out_type;
    logic [ID_W-1:0]   out_src, out_tgt;
    logic [FLIT_W-1:0] out_data;
    logic [3:0]        out_port;

    always #5 clk = ~clk;

    pkt_con_if #(.TYPE_W(TYPE_W), .ID_W(ID_W), .FLIT_W(FLIT_W)) ifc ();

    logic [NL-1:0]             l_vld, l_qos;
    logic [NL-1:0][TYPE_W-1:0] l_typ;
    logic [NL-1:0][ID_W-1:0]   l_src, l_tgt;
    logic [NL-1:0][FLIT_W-1:0] l_data;
    logic [NL-1:0]             act_rdy;
    logic [54:0]               head_act;

    assign ifc.x_vld  = l_vld[6:0];   assign ifc.y_vld  = l_vld[13:7];
    assign ifc.x_qos  = l_qos[6:0];   assign ifc.y_qos  = l_qos[13:7];
    assign ifc.x_type = l_typ[6:0];   assign ifc.y_type = l_typ[13:7];
    assign ifc.x_src  = l_src[6:0];   assign ifc.y_src  = l_src[13:7];
    assign ifc.x_tgt  = l_tgt[6:0];   assign ifc.y_tgt  = l_tgt[13:7];
    assign ifc.x_data = l_data[6:0];  assign ifc.y_data = l_data[13:7];
    assign act_rdy    = {ifc.y_rdy, ifc.x_rdy};
    assign head_act   = {out_qos, out_type, out_src, out_tgt, out_data, out_port};

    pkt_con_rx_arb #(
        .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIM(STARVE_LIM),
        .TYPE_W(TYPE_W), .ID_W(ID_W), .FLIT_W(FLIT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .con(ifc),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_qos(out_qos),
        .out_type(out_type), .out_src(out_src), .out_tgt(out_tgt),
        .out_data(out_data), .out_port(out_port)
    );

    int cmp_cnt = 0;
    int err_cnt = 0;

    // reference model state
    ent_t          mq[$];
    int            mptr_hi, mptr_lo, mstarve;
    logic [NL-1:0] acc, last_rdy;
    bit            auto_drop;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Called just after the negedge once inputs are set: compare, then advance model.
    task automatic settle();
        logic [NL-1:0] hi_v, lo_v, exp_rdy;
        int   gnt, p;
        bit   use_lo, exp_vld;
        ent_t e;
        #2;
        last_rdy = act_rdy;
        if (!rst_n) begin
            chk("rst_out_vld", 64'(out_vld), 64'(0));
            chk("rst_rdy", 64'(act_rdy), 64'(0));
            chk("rst_head", 64'(head_act), 64'(0));
            mq.delete();
            mptr_hi = 0; mptr_lo = 0; mstarve = 0;
            acc = '0;
            return;
        end
        exp_vld = (mq.size() != 0);
        chk("out_vld", 64'(out_vld), 64'(exp_vld));
        if (exp_vld) chk("head", 64'(head_act), 64'(mq[0]));

        hi_v   = l_vld & l_qos;
        lo_v   = l_vld & ~l_qos;
        use_lo = (mstarve == STARVE_LIM && lo_v != 0) || hi_v == 0;
        gnt    = -1;
        if (mq.size() < FIFO_DEPTH) begin
            p = use_lo ? mptr_lo : mptr_hi;
            for (int k = 0; k < NL; k++) begin
                int i = (p + k) % NL;
                if (gnt < 0 && (use_lo ? lo_v[i] : hi_v[i])) gnt = i;
            end
        end
        exp_rdy = (gnt >= 0) ? (NL'(1) << gnt) : '0;
        chk("rdy", 64'(act_rdy), 64'(exp_rdy));
        acc = act_rdy & l_vld;

        if (exp_vld && out_rdy) void'(mq.pop_front());
        if (gnt >= 0) begin
            e.qos = l_qos[gnt]; e.typ = l_typ[gnt]; e.src = l_src[gnt];
            e.tgt = l_tgt[gnt]; e.data = l_data[gnt]; e.port = 4'(gnt);
            mq.push_back(e);
            if (use_lo) mptr_lo = (gnt + 1) % NL;
            else        mptr_hi = (gnt + 1) % NL;
        end
        if (lo_v == 0)               mstarve = 0;
        else if (gnt >= 0 && use_lo) mstarve = 0;
        else if (gnt >= 0)           mstarve = (mstarve < STARVE_LIM) ? mstarve + 1 : mstarve;
    endtask

    task automatic adv();
        @(posedge clk);
        @(negedge clk);
        if (auto_drop) l_vld = l_vld & ~acc;
    endtask

    task automatic cyc();
        settle();
        adv();
    endtask

    initial begin
        l_vld = '0; l_qos = '0; acc = '0; last_rdy = '0; auto_drop = 1'b1;
        mptr_hi = 0; mptr_lo = 0; mstarve = 0;
        for (int i = 0; i < NL; i++) begin
            l_typ[i]  = TYPE_W'(i % 4);
            l_src[i]  = ID_W'(8'h40 + i);
            l_tgt[i]  = ID_W'(8'h80 + i);
            l_data[i] = FLIT_W'(32'hD000_0000 + i);
        end
        cyc();
        rst_n = 1'b1;
        cyc();

        // backpressure: 2 and 5 fill the FIFO, 9 waits, drain keeps order
        out_rdy = 1'b0;
        l_vld[2] = 1'b1; l_vld[5] = 1'b1; l_vld[9] = 1'b1;
        settle(); chk("bp_c0_rdy", 64'(last_rdy), 64'h0004); adv();
        settle(); chk("bp_c1_rdy", 64'(last_rdy), 64'h0020);
                  chk("bp_c1_port", 64'(out_port), 64'd2); adv();
        settle(); chk("bp_c2_rdy", 64'(last_rdy), 64'h0000); adv();
        settle(); chk("bp_c3_rdy", 64'(last_rdy), 64'h0000);
                  chk("bp_c3_port", 64'(out_port), 64'd2);
                  chk("bp_c3_vld", 64'(out_vld), 64'd1); adv();
        out_rdy = 1'b1;
        settle(); chk("bp_full_rdy", 64'(last_rdy), 64'h0000);
                  chk("bp_drain0", 64'(out_port), 64'd2); adv();
        settle(); chk("bp_c5_rdy", 64'(last_rdy), 64'h0200);
                  chk("bp_drain1", 64'(out_port), 64'd5); adv();
        settle(); chk("bp_drain2", 64'(out_port), 64'd9); adv();
        settle(); chk("bp_empty", 64'(out_vld), 64'd0); adv();

        // reset mid-stream with two flits held and a link still requesting
        out_rdy = 1'b0;
        l_vld[1] = 1'b1; l_vld[2] = 1'b1;
        settle(); chk("mr_c0_rdy", 64'(last_rdy), 64'h0002); adv();
        settle(); chk("mr_c1_rdy", 64'(last_rdy), 64'h0004); adv();
        l_vld[11] = 1'b1;
        settle(); chk("mr_full_vld", 64'(out_vld), 64'd1); adv();
        rst_n = 1'b0;
        settle(); chk("mr_vld_drop", 64'(out_vld), 64'd0);
                  chk("mr_rdy_drop", 64'(last_rdy), 64'h0000); adv();
        rst_n = 1'b1;

        // round-robin sweep over all 14 links, restarting from index 0
        auto_drop = 1'b0; out_rdy = 1'b1;
        l_vld = '1; l_qos = '0;
        for (int c = 0; c < 2 * NL; c++) begin
            settle(); chk("rr_grant", 64'(last_rdy), 64'(NL'(1) << (c % NL))); adv();
        end

        // QoS with anti-starvation: 8 grants to index 7, then 1 to index 0
        l_vld = '0; l_qos = '0;
        l_vld[7] = 1'b1; l_qos[7] = 1'b1; l_vld[0] = 1'b1;
        for (int c = 0; c < 30; c++) begin
            settle(); chk("qos_grant", 64'(last_rdy), (c % 9 < 8) ? 64'h0080 : 64'h0001); adv();
        end
        l_vld[0] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            settle(); chk("qos_hi_only", 64'(last_rdy), 64'h0080); adv();
        end
        l_vld[0] = 1'b1;
        for (int c = 0; c < 9; c++) begin
            settle(); chk("qos_restart", 64'(last_rdy), (c < 8) ? 64'h0080 : 64'h0001); adv();
        end

        // simultaneous push/pop with one requester
        l_vld = '0; l_vld[4] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            settle(); chk("pp_rdy", 64'(last_rdy), 64'h0010);
            if (c >= 1) chk("pp_port", 64'(out_port), 64'd4);
            adv();
        end
        l_vld = '0;
        cyc(); cyc();

        // single flit latency and payload
        auto_drop = 1'b1;
        l_src[3] = 8'h12; l_data[3] = 32'h0000_00A5; l_vld[3] = 1'b1;
        settle(); chk("sf_rdy", 64'(last_rdy), 64'h0008); adv();
        settle(); chk("sf_vld", 64'(out_vld), 64'd1);
                  chk("sf_port", 64'(out_port), 64'd3);
                  chk("sf_src", 64'(out_src), 64'h12);
                  chk("sf_data", 64'(out_data), 64'hA5); adv();
        cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/pkt_con_rx_arb.md
Name: pkt_con_rx_arb

Overview:
- Node-side consumer of the pkt_con_if slv modport.
- Merges the 14 point-to-point inbound links into one ejection stream:
  - X_DIRECTION = 7 same-x links, indices 0..6 (x_i).
  - Y_DIRECTION = 7 same-y links, indices 7..13 (y_(i-7)).
- Arbitration is two-class QoS-priority round-robin with low-class anti-starvation.
- Accepted flits pass through a small output FIFO into the node's local sink.
- One flit per packet. No multi-flit locking.

Parameters:
- FIFO_DEPTH, 2, output FIFO entries. Legal values: 2..8.
- STARVE_LIM, 8, number of consecutive high-QoS grants, with low-QoS requests pending, before one low-QoS grant is forced. Legal values: 1..255.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- con  interface  pkt_con_if.slv  14 inbound links. Uses x_/y_ vld, qos, type, src, tgt, data as inputs and x_rdy/y_rdy as outputs.
- out_vld  output  1  output FIFO head valid.
- out_rdy  input  1  sink ready.
- out_qos  output  1  head flit qos.
- out_type  output  TYPE_W  head flit type.
- out_src  output  ID_W  head flit source id.
- out_tgt  output  ID_W  head flit target id.
- out_data  output  FLIT_W  head flit payload.
- out_port  output  4  link index (0..13) the head flit arrived on.

Behaviour:
- Clock/reset: one clock, clk. Reset is rst_n, asynchronous, active-low.
- Reset values:
  - out_vld=0 and all x_rdy/y_rdy=0.
  - FIFO count=0; both RR pointers=0; starve_cnt=0.
  - out_qos/type/src/tgt/data/port=0.
- Reset mid-operation: FIFO contents are discarded and out_vld drops asynchronously. No partial state survives.
- Request vectors: req[i] = vld of link i. hi = req & qos; lo = req & ~qos.
- space = (count < FIFO_DEPTH). Pop-through into a full FIFO is not allowed; a full FIFO accepts nothing in that cycle even if out_rdy=1.
- Class select (combinational, only when space):
  - Step 1: if starve_cnt == STARVE_LIM and lo != 0, select lo.
  - Step 2: otherwise, if hi != 0, select hi.
  - Step 3: otherwise, select lo.
- Within the selected class, grant the first requesting index at or above that class's pointer, wrapping 13 -> 0.
- rdy for the granted link only is asserted in the same cycle. All other rdy=0, and all rdy=0 when !space or no request.
- rdy may depend combinationally on vld. The block never makes vld-dependent decisions on rdy.
- Transfer = vld & rdy on the granted link. Every asserted rdy is a transfer.
- On transfer:
  - Push {qos, type, src, tgt, data, index} into the FIFO.
  - The selected class pointer becomes (g+1) mod 14. The other class pointer is unchanged.
- starve_cnt update, registered:
  - Cycle with a hi transfer and lo != 0: +1, saturating at STARVE_LIM.
  - Cycle with a lo transfer: 0.
  - Cycle with lo == 0: 0.
  - Otherwise: hold.
- FIFO:
  - Strict order. Outputs are driven from the head entry.
  - Pop occurs on out_vld & out_rdy.
  - Push and pop in the same cycle leave count unchanged.
  - out_vld = (count != 0).
  - Head payload is stable while out_vld & !out_rdy.
- Latency: a flit accepted in cycle N into an empty FIFO is presented at out_* in cycle N+1. Throughput is 1 flit/cycle with out_rdy held high.
- Upstream obligation, not checked: vld with stable payload is held until accepted.

Test Plan:
- Reset check: assert rst_n=0 mid-stream with FIFO holding 2 flits -> out_vld=0 and all rdy=0 immediately. After release, the next grant starts from index 0.
- Single flit: x_vld[3]=1, qos=0, src=0x12, data=0xA5, out_rdy=1 -> x_rdy[3]=1 in the same cycle. Next cycle: out_vld=1, out_port=3, out_src=0x12, out_data=0xA5.
- Round-robin: all 14 vld=1, qos=0, held, out_rdy=1 -> grant order is 0,1,...,13,0,1,... at one grant per cycle. No link is skipped or granted twice within a sweep.
- QoS/starvation: y_vld[0] (index 7) qos=1 and x_vld[0] qos=0, both held; STARVE_LIM=8 -> index 7 wins 8 grants, index 0 wins 1 grant, repeating. With x_vld[0] removed, index 7 gets every grant and starve_cnt stays 0.
- Backpressure: out_rdy=0 with links 2, 5, 9 requesting -> links 2 then 5 accepted, then all rdy=0. out_vld=1 with out_port=2 held stable. Raising out_rdy drains 2, 5, then 9, in order.
- Simultaneous push/pop: FIFO count=1 with out_rdy=1 and one requester -> count stays 1 and a new flit is accepted every cycle.
